// File: rtl/vend_pkg.sv
// Shared definitions for the change dispense sequencer: coin codes,
// denomination values, FSM state encodings and small coin helpers.
package vend_pkg;

    // Coin codes driven on the eject bus
    localparam logic [2:0] COIN_NONE    = 3'b000;
    localparam logic [2:0] COIN_NICKEL  = 3'b001;
    localparam logic [2:0] COIN_DIME    = 3'b010;
    localparam logic [2:0] COIN_QUARTER = 3'b011;
    localparam logic [2:0] COIN_DOLLAR  = 3'b100;

    // Denomination values in cents
    localparam logic [6:0] VAL_NICKEL  = 7'd5;
    localparam logic [6:0] VAL_DIME    = 7'd10;
    localparam logic [6:0] VAL_QUARTER = 7'd25;
    localparam logic [6:0] VAL_DOLLAR  = 7'd100;

    // Sequencer state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_EJECT  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Cent value of a coin code (0 for none/illegal codes)
    function automatic logic [6:0] coin_value(input logic [2:0] code);
        case (code)
            COIN_NICKEL:  coin_value = VAL_NICKEL;
            COIN_DIME:    coin_value = VAL_DIME;
            COIN_QUARTER: coin_value = VAL_QUARTER;
            COIN_DOLLAR:  coin_value = VAL_DOLLAR;
            default:      coin_value = 7'd0;
        endcase
    endfunction

    // One-hot hopper bit for a coin code, same ordering as hopper_empty
    function automatic logic [3:0] coin_hopper_bit(input logic [2:0] code);
        case (code)
            COIN_NICKEL:  coin_hopper_bit = 4'b0001;
            COIN_DIME:    coin_hopper_bit = 4'b0010;
            COIN_QUARTER: coin_hopper_bit = 4'b0100;
            COIN_DOLLAR:  coin_hopper_bit = 4'b1000;
            default:      coin_hopper_bit = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// Hopper acknowledge watchdog. Counts cycles while run is high and flags
// expiry on the TIMEOUT_CYC-th consecutive cycle; clears whenever run drops.
module dispense_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [CW-1:0] count;

    // Cycle counter, restarted every time the sequencer leaves EJECT
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = run && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/change_dispense_sequencer.sv
// Change dispense sequencer: pays out a requested amount greedily from the
// dollar/quarter/dime/nickel hoppers, one acknowledged coin at a time, and
// reports the undispensed remainder on completion.
// Optional feature: define DISPENSE_TIMEOUT_EN to add a hopper-ack watchdog
// that masks a hopper which fails to acknowledge and raises a sticky error.
module change_dispense_sequencer
    import vend_pkg::*;
#(
    parameter int AMOUNT_W    = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AMOUNT_W-1:0] req_amount,
    input  logic [3:0]          hopper_empty,
    output logic [2:0]          eject,
    output logic                eject_valid,
    input  logic                eject_ack,
    output logic                done,
    output logic [AMOUNT_W-1:0] short,
    output logic                error
);

    // Comparisons against denomination values need at least 8 bits
    localparam int VW = (AMOUNT_W > 8) ? AMOUNT_W : 8;

    logic [1:0]          state;
    logic [AMOUNT_W-1:0] remaining;
    logic [VW-1:0]       rem_ext;
    logic [AMOUNT_W-1:0] amt_mod5;
    logic [3:0]          fault_mask;
    logic [3:0]          avail;
    logic [2:0]          pick;
    logic                timeout;

    assign rem_ext  = VW'(remaining);
    assign amt_mod5 = AMOUNT_W'(VW'(req_amount) % VW'(5));
    assign avail    = ~hopper_empty & ~fault_mask;

    assign req_ready   = (state == ST_IDLE);
    assign eject_valid = (state == ST_EJECT);
    assign done        = (state == ST_DONE);

    // Largest usable denomination that still fits in the remaining amount
    always_comb begin
        pick = COIN_NONE;
        if (avail[3] && rem_ext >= VW'(VAL_DOLLAR)) begin
            pick = COIN_DOLLAR;
        end else if (avail[2] && rem_ext >= VW'(VAL_QUARTER)) begin
            pick = COIN_QUARTER;
        end else if (avail[1] && rem_ext >= VW'(VAL_DIME)) begin
            pick = COIN_DIME;
        end else if (avail[0] && rem_ext >= VW'(VAL_NICKEL)) begin
            pick = COIN_NICKEL;
        end
    end

    // Main sequencer: capture, select, eject/ack, completion
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            eject     <= COIN_NONE;
            short     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Sub-nickel cents can never be paid; book them short now
                        remaining <= req_amount - amt_mod5;
                        short     <= amt_mod5;
                        state     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (remaining == '0) begin
                        state <= ST_DONE;
                    end else if (pick == COIN_NONE) begin
                        short     <= short + remaining;
                        remaining <= '0;
                        state     <= ST_DONE;
                    end else begin
                        eject <= pick;
                        state <= ST_EJECT;
                    end
                end
                ST_EJECT: begin
                    // A coin is only chosen when it fits, so this cannot underflow
                    if (eject_ack) begin
                        remaining <= remaining - AMOUNT_W'(coin_value(eject));
                        eject     <= COIN_NONE;
                        state     <= ST_SELECT;
                    end else if (timeout) begin
                        eject <= COIN_NONE;
                        state <= ST_SELECT;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DISPENSE_TIMEOUT_EN
    logic timer_expired;

    dispense_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (state == ST_EJECT),
        .expired (timer_expired)
    );

    // An ack arriving on the expiry cycle still counts as a dispensed coin
    assign timeout = timer_expired && !eject_ack;

    // Sticky per-hopper fault mask and error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_mask <= 4'b0000;
            error      <= 1'b0;
        end else if (state == ST_EJECT && timeout) begin
            fault_mask <= fault_mask | coin_hopper_bit(eject);
            error      <= 1'b1;
        end
    end
`else
    // Keeps the timeout parameter referenced in builds without the watchdog
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);

    assign timeout    = 1'b0;
    assign fault_mask = 4'b0000;
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispense_sequencer.sv
// Randomized self-checking bench for change_dispense_sequencer with a
// greedy-change reference model.
module tb_change_dispense_sequencer;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_amount;
    logic [3:0]    hopper_empty;
    logic [2:0]    eject;
    logic          eject_valid;
    logic          eject_ack;
    logic          done;
    logic [AW-1:0] short;
    logic          error;

    always #5 clk = ~clk;

    change_dispense_sequencer #(
        .AMOUNT_W    (AW),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_amount   (req_amount),
        .hopper_empty (hopper_empty),
        .eject        (eject),
        .eject_valid  (eject_valid),
        .eject_ack    (eject_ack),
        .done         (done),
        .short        (short),
        .error        (error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: expected coin codes and short for one request
    int exp_q[$];
    int exp_short;

    function automatic void model(input int amt, input logic [3:0] emp);
        int  vals[4]  = '{100, 25, 10, 5};
        int  codes[4] = '{4, 3, 2, 1};
        int  rem;
        bit  found;
        exp_q.delete();
        exp_short = amt % 5;
        rem = amt - exp_short;
        while (rem > 0) begin
            found = 0;
            for (int i = 0; i < 4; i++) begin
                if (!found && !emp[3-i] && vals[i] <= rem) begin
                    exp_q.push_back(codes[i]);
                    rem   = rem - vals[i];
                    found = 1;
                end
            end
            if (!found) begin
                exp_short = exp_short + rem;
                rem = 0;
            end
        end
    endfunction

    // One full request; hopper acks after 0..max_delay cycles
    task automatic run_txn(input int amt, input logic [3:0] emp, input int max_delay);
        int       k;
        int       wait_n;
        logic     in_ej;
        logic [2:0] held;
        bit       seen_done;
        model(amt, emp);
        @(negedge clk);
        check("ready_idle", req_ready, 1);
        req_valid    = 1'b1;
        req_amount   = amt[AW-1:0];
        hopper_empty = emp;
        eject_ack    = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("ready_busy", req_ready, 0);
        k = 0; in_ej = 0; held = 3'b000; wait_n = 0; seen_done = 0;
        for (int budget = 0; budget < 1000 && !seen_done; budget++) begin
            if (done) begin
                seen_done = 1;
                eject_ack = 1'b0;
                check("short", short, exp_short);
                check("coin_count", k, exp_q.size());
            end else if (eject_valid) begin
                if (!in_ej) begin
                    check("eject_code", eject, (k < exp_q.size()) ? exp_q[k] : 0);
                    held   = eject;
                    in_ej  = 1;
                    wait_n = $urandom_range(0, max_delay);
                end else begin
                    check("eject_hold", eject, held);
                end
                if (wait_n == 0) begin
                    eject_ack    = 1'b1;
                    hopper_empty = emp;
                    k++;
                    in_ej = 0;
                end else begin
                    // Hopper status may wander while a coin is in flight
                    eject_ack    = 1'b0;
                    hopper_empty = 4'($urandom_range(0, 15));
                    wait_n--;
                end
            end else begin
                eject_ack = 1'($urandom_range(0, 1));
            end
            if (!seen_done) @(negedge clk);
        end
        if (!seen_done) check("done_timeout", 0, 1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("ready_after", req_ready, 1);
        eject_ack = 1'b0;
    endtask

    int cnt;

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_amount   = '0;
        hopper_empty = 4'b0000;
        eject_ack    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_eject", eject, 0);
        check("rst_eject_valid", eject_valid, 0);
        check("rst_done", done, 0);
        check("rst_short", short, 0);
        check("rst_error", error, 0);
        reset = 1'b0;

        run_txn(65, 4'b0000, 0);
        run_txn(150, 4'b1000, 0);
        run_txn(40, 4'b0111, 0);
        run_txn(37, 4'b0000, 1);
        run_txn(3, 4'b0000, 0);
        run_txn(0, 4'b0000, 0);
        run_txn(255, 4'b0000, 2);

        // Reset while a coin is being ejected
        @(negedge clk);
        req_valid = 1'b1; req_amount = 8'd100; hopper_empty = 4'b0000; eject_ack = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        cnt = 0;
        while (!eject_valid && cnt < 10) begin
            cnt++;
            @(negedge clk);
        end
        check("mid_reach_eject", eject_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_eject", eject, 0);
        check("mid_rst_eject_valid", eject_valid, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_short", short, 0);
        check("mid_rst_error", error, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_done", done, 0);
        end

        for (int t = 0; t < 40; t++) begin
            run_txn($urandom_range(0, 255), 4'($urandom_range(0, 15)), 3);
        end

`ifdef DISPENSE_TIMEOUT_EN
        // Quarter hopper never acknowledges; dimes and nickels are empty
        @(negedge clk);
        req_valid = 1'b1; req_amount = 8'd25; hopper_empty = 4'b0011; eject_ack = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("to_eject_code", eject, 3);
        cnt = 0;
        while (eject_valid && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check("to_cycles", cnt, 8);
        check("to_error", error, 1);
        cnt = 0;
        while (!done && cnt < 10) begin
            cnt++;
            @(negedge clk);
        end
        check("to_done", done, 1);
        check("to_short", short, 25);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispense_sequencer.md
CHANGE_DISPENSE_SEQUENCER -- requirements
Module: change_dispense_sequencer

Interface
REQ-001 SHALL have parameter AMOUNT_W, default 8, width in bits of change amount in cents.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000, cycles allowed for a hopper ack.
REQ-003 SHALL have ports: clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports: req_valid  input  1  change request present.
REQ-006 SHALL have ports: req_ready  output  1  sequencer can accept a request.
REQ-007 SHALL have ports: req_amount  input  AMOUNT_W  change owed, cents.
REQ-008 SHALL have ports: hopper_empty  input  4  [0] nickel, [1] dime, [2] quarter, [3] dollar; 1 = empty.
REQ-009 SHALL have ports: eject  output  3  coin code: 001 nickel, 010 dime, 011 quarter, 100 dollar, 000 none.
REQ-010 SHALL have ports: eject_valid  output  1  eject command active.
REQ-011 SHALL have ports: eject_ack  input  1  hopper confirms one coin dropped.
REQ-012 SHALL have ports: done  output  1  one-cycle completion pulse.
REQ-013 SHALL have ports: short  output  AMOUNT_W  cents not dispensed; valid while done=1.
REQ-014 SHALL have ports: error  output  1  sticky hopper-timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, SELECT, EJECT, DONE.
REQ-016 In IDLE, req_ready SHALL be 1; on req_valid=1, req_amount SHALL be captured into remaining and the FSM SHALL go to SELECT; req_ready SHALL be 0 in all other states.
REQ-017 The amount mod 5 SHALL be dropped from remaining at capture and added to short.
REQ-018 In SELECT, the largest denomination (100, 25, 10, 5) with value <= remaining, hopper not empty and not fault-masked SHALL be chosen; the FSM SHALL go to EJECT with eject set to its code.
REQ-019 In SELECT with remaining = 0, the FSM SHALL go to DONE.
REQ-020 In SELECT with no eligible denomination, the FSM SHALL go to DONE, adding remaining to short.
REQ-021 In EJECT, eject_valid SHALL be 1 and eject SHALL be held stable until eject_ack=1.
REQ-022 On eject_ack in EJECT, the coin value SHALL be subtracted from remaining and the FSM SHALL return to SELECT.
REQ-023 eject_ack outside EJECT SHALL be ignored.
REQ-024 hopper_empty SHALL be sampled only in SELECT; a change during EJECT SHALL not abort the eject.
REQ-025 In DONE, done SHALL be 1 for exactly one cycle with short valid, then the FSM SHALL go to IDLE.
REQ-026 Subtraction SHALL never underflow; remaining SHALL be AMOUNT_W bits unsigned.
REQ-027 A request with amount < 5 SHALL complete as IDLE -> SELECT -> DONE with no eject.

Reset
REQ-028 Reset SHALL force IDLE, remaining=0, eject=000, eject_valid=0, done=0, short=0, error=0, fault mask=0000, timer=0.
REQ-029 Reset mid-eject SHALL abandon the request with no done pulse.

Configuration
REQ-030 With DISPENSE_TIMEOUT_EN defined, a counter SHALL run in EJECT; at TIMEOUT_CYC cycles without ack it SHALL set that hopper's sticky fault-mask bit, set error, drop eject_valid and go to SELECT.
REQ-031 Without DISPENSE_TIMEOUT_EN, EJECT SHALL wait indefinitely, error SHALL be constant 0 and no counter SHALL be synthesized.

Structure
REQ-032 Coin codes, denomination values and state encodings SHALL live in shared package vend_pkg.
REQ-033 The timeout counter SHALL be sub-module dispense_timer, instantiated only under DISPENSE_TIMEOUT_EN.

Verification
REQ-034 amount=65, all hoppers full, ack same cycle as eject_valid -> ejects 011,011,010,001; done in cycle 9 after capture; short=0.
REQ-035 amount=150, hopper_empty=1000 -> six 011 ejects; short=0.
REQ-036 amount=40, hopper_empty=0111 -> no eject; done with short=40.
REQ-037 amount=37 -> ejects 011,010; short=2.
REQ-038 DISPENSE_TIMEOUT_EN, TIMEOUT_CYC=8, amount=25, no ack -> eject_valid drops after 8 cycles, error=1; done with short=25 (dimes/nickels empty).
REQ-039 Reset asserted during EJECT -> next cycle all outputs at reset values; req_ready=1.
